// File: rtl/ofs_fim_pcie_ss_pipe_tx_ib2sb.sv
// ---------------------------------------------------------------------------
// ofs_fim_pcie_ss_pipe_tx_ib2sb
//
// Purpose:
//   Merges the two FIM TX streams into one. The merge is packet-granular and
//   round-robin. "tx" carries completions and writes. "txreq" carries read
//   requests. The merged stream is converted from the in-band header format
//   to the PCIe SS side-band header format:
//     - the 256-bit header in the lower half of beat 0 moves to tuser_hdr;
//     - the payload is re-aligned down by 256 bits.
//   The block sits on the FIM clock, ahead of the TX clock-crossing FIFO.
//
// Optional feature:
//   `define OFS_FIM_PCIE_SS_TX_IB2SB_STATS_EN enables per-source 32-bit
//   packet counters. When the macro is undefined, the stat outputs are
//   tied to 0.
//
// Ports:
//   clk, rst_n              FIM clock, synchronous active-low reset
//   tx_*                    tx input stream (AXI-S, header in-band)
//   txreq_*                 txreq input stream (AXI-S, header in-band)
//   out_*                   merged side-band output (single register stage)
//   stat_tx_pkts            packets accepted from tx
//   stat_txreq_pkts         packets accepted from txreq
// ---------------------------------------------------------------------------
module ofs_fim_pcie_ss_pipe_tx_ib2sb #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int HDR_WIDTH   = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_tvalid,
  output logic                   tx_tready,
  input  logic [TDATA_WIDTH-1:0] tx_tdata,
  input  logic [TKEEP_WIDTH-1:0] tx_tkeep,
  input  logic                   tx_tlast,
  input  logic                   tx_tuser_vendor,
  input  logic                   txreq_tvalid,
  output logic                   txreq_tready,
  input  logic [TDATA_WIDTH-1:0] txreq_tdata,
  input  logic [TKEEP_WIDTH-1:0] txreq_tkeep,
  input  logic                   txreq_tlast,
  input  logic                   txreq_tuser_vendor,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [TDATA_WIDTH-1:0] out_tdata,
  output logic [TKEEP_WIDTH-1:0] out_tkeep,
  output logic                   out_tlast,
  output logic                   out_tuser_vendor,
  output logic                   out_tuser_hvalid,
  output logic [HDR_WIDTH-1:0]   out_tuser_hdr,
  output logic                   out_tuser_last_segment,
  output logic [31:0]            stat_tx_pkts,
  output logic [31:0]            stat_txreq_pkts
);

  localparam int HW = TDATA_WIDTH / 2;
  localparam int KW = TKEEP_WIDTH / 2;

  if (TDATA_WIDTH != 512 || HDR_WIDTH != HW || TKEEP_WIDTH != TDATA_WIDTH / 8) begin : g_bad_cfg
    $error("ofs_fim_pcie_ss_pipe_tx_ib2sb: only TDATA_WIDTH=512 with HDR_WIDTH=256 is supported");
  end

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   rr_q, rr_d;        // 0: tx has priority, 1: txreq
  logic                   gnt_q, gnt_d;      // source locked for the current packet
  logic [HDR_WIDTH-1:0]   hdr_q, hdr_d;
  logic [HW-1:0]          hold_data_q, hold_data_d;
  logic [KW-1:0]          hold_keep_q, hold_keep_d;
  logic                   vend_q, vend_d;
  logic                   first_q, first_d;  // next output beat carries the header

  logic                   out_tvalid_q, out_tvalid_d;
  logic [TDATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic [TKEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
  logic                   out_tlast_q, out_tlast_d;
  logic                   out_vend_q, out_vend_d;
  logic                   out_hvalid_q, out_hvalid_d;
  logic [HDR_WIDTH-1:0]   out_hdr_q, out_hdr_d;

  logic                   can_load_s;
  logic                   sel_s;
  logic                   in_valid_s;
  logic [TDATA_WIDTH-1:0] in_data_s;
  logic [TKEEP_WIDTH-1:0] in_keep_s;
  logic                   in_last_s;
  logic                   in_vend_s;
  logic                   accept_s;

  // Source select, input mux and ready generation.
  always_comb begin
    can_load_s = !out_tvalid_q || out_tready;
    if (state_q == ST_ARB) begin
      // Round-robin only matters when both sides request.
      sel_s = (tx_tvalid && txreq_tvalid) ? rr_q : (!tx_tvalid && txreq_tvalid);
    end else begin
      sel_s = gnt_q;
    end
    if (sel_s) begin
      in_valid_s = txreq_tvalid;
      in_data_s  = txreq_tdata;
      in_keep_s  = txreq_tkeep;
      in_last_s  = txreq_tlast;
      in_vend_s  = txreq_tuser_vendor;
    end else begin
      in_valid_s = tx_tvalid;
      in_data_s  = tx_tdata;
      in_keep_s  = tx_tkeep;
      in_last_s  = tx_tlast;
      in_vend_s  = tx_tuser_vendor;
    end
    // Ready is gated by rst_n so no beat can be taken while reset is applied.
    accept_s     = rst_n && (state_q != ST_FLUSH) && in_valid_s && can_load_s;
    tx_tready    = rst_n && (state_q != ST_FLUSH) && in_valid_s && can_load_s && !sel_s;
    txreq_tready = rst_n && (state_q != ST_FLUSH) && in_valid_s && can_load_s && sel_s;
  end

  // Next-state, header/hold capture and output-beat construction.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    hdr_d       = hdr_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    vend_d      = vend_q;
    first_d     = first_q;
    if (can_load_s) begin
      // A drained beat leaves the output register empty and zeroed.
      out_tvalid_d = 1'b0;
      out_tdata_d  = '0;
      out_tkeep_d  = '0;
      out_tlast_d  = 1'b0;
      out_vend_d   = 1'b0;
      out_hvalid_d = 1'b0;
      out_hdr_d    = '0;
    end else begin
      out_tvalid_d = out_tvalid_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tlast_d  = out_tlast_q;
      out_vend_d   = out_vend_q;
      out_hvalid_d = out_hvalid_q;
      out_hdr_d    = out_hdr_q;
    end

    case (state_q)
      ST_ARB: begin
        if (accept_s) begin
          gnt_d       = sel_s;
          hdr_d       = in_data_s[HW-1:0];
          hold_data_d = in_data_s[TDATA_WIDTH-1:HW];
          hold_keep_d = in_keep_s[TKEEP_WIDTH-1:KW];
          vend_d      = in_vend_s;
          if (in_last_s) begin
            // A single-beat packet yields exactly one beat. It may be header-only.
            out_tvalid_d = 1'b1;
            out_tdata_d  = {{HW{1'b0}}, in_data_s[TDATA_WIDTH-1:HW]};
            out_tkeep_d  = {{KW{1'b0}}, in_keep_s[TKEEP_WIDTH-1:KW]};
            out_tlast_d  = 1'b1;
            out_vend_d   = in_vend_s;
            out_hvalid_d = 1'b1;
            out_hdr_d    = in_data_s[HW-1:0];
            rr_d         = !sel_s;
            first_d      = 1'b0;
            state_d      = ST_ARB;
          end else begin
            first_d = 1'b1;
            state_d = ST_BODY;
          end
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_BODY: begin
        if (accept_s) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = {in_data_s[HW-1:0], hold_data_q};
          out_tkeep_d  = {in_keep_s[KW-1:0], hold_keep_q};
          out_vend_d   = vend_q;
          out_hvalid_d = first_q;
          out_hdr_d    = first_q ? hdr_q : {HDR_WIDTH{1'b0}};
          first_d      = 1'b0;
          hold_data_d  = in_data_s[TDATA_WIDTH-1:HW];
          hold_keep_d  = in_keep_s[TKEEP_WIDTH-1:KW];
          if (in_last_s) begin
            rr_d = !gnt_q;
            if (in_keep_s[TKEEP_WIDTH-1:KW] == {KW{1'b0}}) begin
              out_tlast_d = 1'b1;
              state_d     = ST_ARB;
            end else begin
              // The upper half still holds payload and needs one more beat.
              out_tlast_d = 1'b0;
              state_d     = ST_FLUSH;
            end
          end else begin
            out_tlast_d = 1'b0;
            state_d     = ST_BODY;
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_FLUSH: begin
        if (can_load_s) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = {{HW{1'b0}}, hold_data_q};
          out_tkeep_d  = {{KW{1'b0}}, hold_keep_q};
          out_tlast_d  = 1'b1;
          out_vend_d   = vend_q;
          out_hvalid_d = 1'b0;
          out_hdr_d    = '0;
          state_d      = ST_ARB;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State, hold and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      rr_q         <= 1'b0;
      gnt_q        <= 1'b0;
      hdr_q        <= '0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      vend_q       <= 1'b0;
      first_q      <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_vend_q   <= 1'b0;
      out_hvalid_q <= 1'b0;
      out_hdr_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      hdr_q        <= hdr_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      vend_q       <= vend_d;
      first_q      <= first_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_vend_q   <= out_vend_d;
      out_hvalid_q <= out_hvalid_d;
      out_hdr_q    <= out_hdr_d;
    end
  end

  assign out_tvalid             = out_tvalid_q;
  assign out_tdata              = out_tdata_q;
  assign out_tkeep              = out_tkeep_q;
  assign out_tlast              = out_tlast_q;
  assign out_tuser_last_segment = out_tlast_q;
  assign out_tuser_vendor       = out_vend_q;
  assign out_tuser_hvalid       = out_hvalid_q;
  assign out_tuser_hdr          = out_hdr_q;

`ifdef OFS_FIM_PCIE_SS_TX_IB2SB_STATS_EN
  logic [31:0] stat_tx_q, stat_tx_d;
  logic [31:0] stat_txreq_q, stat_txreq_d;

  // Packet counters step on the accepted last beat of each source and wrap.
  always_comb begin
    stat_tx_d    = stat_tx_q;
    stat_txreq_d = stat_txreq_q;
    if (accept_s && in_last_s) begin
      if (sel_s) begin
        stat_txreq_d = stat_txreq_q + 32'd1;
      end else begin
        stat_tx_d = stat_tx_q + 32'd1;
      end
    end else begin
      stat_tx_d    = stat_tx_q;
      stat_txreq_d = stat_txreq_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_tx_q    <= 32'd0;
      stat_txreq_q <= 32'd0;
    end else begin
      stat_tx_q    <= stat_tx_d;
      stat_txreq_q <= stat_txreq_d;
    end
  end

  assign stat_tx_pkts    = stat_tx_q;
  assign stat_txreq_pkts = stat_txreq_q;
`else
  assign stat_tx_pkts    = 32'd0;
  assign stat_txreq_pkts = 32'd0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_pipe_tx_ib2sb.sv
// ---------------------------------------------------------------------------
// Testbench for ofs_fim_pcie_ss_pipe_tx_ib2sb.
// Input packets come from a vector table plus a few hand-written sequences.
// The expected output beats of each packet are derived independently: the
// packet is treated as one flat bit string, the 256-bit header is dropped,
// and the rest is cut into 512-bit chunks. These beats are queued when a
// packet is driven and popped by a monitor as the DUT emits beats.
// ---------------------------------------------------------------------------
module tb_ofs_fim_pcie_ss_pipe_tx_ib2sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         tx_tvalid, tx_tready, tx_tlast, tx_tuser_vendor;
  logic [511:0] tx_tdata;
  logic [63:0]  tx_tkeep;
  logic         txreq_tvalid, txreq_tready, txreq_tlast, txreq_tuser_vendor;
  logic [511:0] txreq_tdata;
  logic [63:0]  txreq_tkeep;
  logic         out_tvalid, out_tready, out_tlast, out_tuser_vendor;
  logic         out_tuser_hvalid, out_tuser_last_segment;
  logic [511:0] out_tdata;
  logic [63:0]  out_tkeep;
  logic [255:0] out_tuser_hdr;
  logic [31:0]  stat_tx_pkts, stat_txreq_pkts;

  ofs_fim_pcie_ss_pipe_tx_ib2sb dut (
    .clk(clk), .rst_n(rst_n),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser_vendor(tx_tuser_vendor),
    .txreq_tvalid(txreq_tvalid), .txreq_tready(txreq_tready), .txreq_tdata(txreq_tdata),
    .txreq_tkeep(txreq_tkeep), .txreq_tlast(txreq_tlast), .txreq_tuser_vendor(txreq_tuser_vendor),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser_vendor(out_tuser_vendor),
    .out_tuser_hvalid(out_tuser_hvalid), .out_tuser_hdr(out_tuser_hdr),
    .out_tuser_last_segment(out_tuser_last_segment),
    .stat_tx_pkts(stat_tx_pkts), .stat_txreq_pkts(stat_txreq_pkts)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         vendor;
    logic         hvalid;
    logic [255:0] hdr;
  } beat_t;

  typedef struct {
    int               n;
    logic             vend;
    logic [7:0][511:0] d;
    logic [7:0][63:0]  k;
  } pkt_t;

  typedef struct {
    int src;        // 0 = tx, 1 = txreq
    int n;          // input beats
    bit up;         // last input beat has upper-half keep set
    bit vend;
    int exp_beats;  // output beats expected
  } vec_t;

  beat_t sbq[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    beats_seen = 0;
  int    cnt_tx = 0;
  int    cnt_rq = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic pkt_t make_pkt(input int n, input bit up, input bit vend, input bit a5);
    pkt_t p;
    p.n = n;
    p.vend = vend;
    p.d = '0;
    p.k = '0;
    for (int i = 0; i < n; i++) begin
      p.d[i] = rnd512();
      p.k[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    if (a5) p.d[0][255:0] = {32{8'hA5}};
    if (n == 1) p.k[0] = up ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    else        p.k[n-1] = up ? 64'h0000_000F_FFFF_FFFF : 64'h0000_0000_00FF_FFFF;
    return p;
  endfunction

  // Expected beats: flat bit string minus the header, in 512-bit chunks.
  task automatic predict(input pkt_t p);
    logic [4607:0] all;
    logic [575:0]  kall;
    beat_t         b;
    int            nb;
    all = '0;
    kall = '0;
    for (int i = 0; i < p.n; i++) begin
      all[i*512 +: 512] = p.d[i];
      kall[i*64 +: 64]  = p.k[i];
    end
    nb = (p.n == 1 || kall[32 + 64*(p.n-1) +: 64] != 64'h0) ? p.n : p.n - 1;
    for (int k = 0; k < nb; k++) begin
      b.data   = all[256 + 512*k +: 512];
      b.keep   = kall[32 + 64*k +: 64];
      b.last   = (k == nb - 1);
      b.vendor = p.vend;
      b.hvalid = (k == 0);
      b.hdr    = (k == 0) ? p.d[0][255:0] : 256'h0;
      sbq.push_back(b);
    end
  endtask

  task automatic send_beat(input int src, input logic [511:0] d, input logic [63:0] k,
                           input logic l, input logic v);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    if (src == 0) begin
      tx_tvalid = 1'b1; tx_tdata = d; tx_tkeep = k; tx_tlast = l; tx_tuser_vendor = v;
    end else begin
      txreq_tvalid = 1'b1; txreq_tdata = d; txreq_tkeep = k; txreq_tlast = l; txreq_tuser_vendor = v;
    end
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = (src == 0) ? tx_tready : txreq_tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (src == 0) tx_tvalid = 1'b0;
    else          txreq_tvalid = 1'b0;
    chk("handshake", 512'(ok), 512'(1'b1));
  endtask

  task automatic send_pkt(input int src, input pkt_t p);
    for (int i = 0; i < p.n; i++) send_beat(src, p.d[i], p.k[i], (i == p.n - 1), p.vend);
    if (src == 0) cnt_tx++;
    else          cnt_rq++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 512'(sbq.size()), 512'(0));
  endtask

  // Output monitor: scoreboard compare on each transfer, plus stability of held beats.
  beat_t mon_e;
  beat_t prev;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("stall_data", out_tdata, prev.data);
      chk("stall_ctl", 512'({out_tkeep, out_tlast, out_tuser_vendor, out_tuser_hvalid, out_tuser_hdr}),
          512'({prev.keep, prev.last, prev.vendor, prev.hvalid, prev.hdr}));
    end
    if (rst_n && out_tvalid && out_tready) begin
      beats_seen++;
      if (sbq.size() == 0) begin
        chk("unexpected_beat", 512'(1'b1), 512'(1'b0));
      end else begin
        mon_e = sbq.pop_front();
        chk("beat_data", out_tdata, mon_e.data);
        chk("beat_ctl", 512'({out_tkeep, out_tlast, out_tuser_last_segment, out_tuser_vendor, out_tuser_hvalid}),
            512'({mon_e.keep, mon_e.last, mon_e.last, mon_e.vendor, mon_e.hvalid}));
        chk("beat_hdr", 512'(out_tuser_hdr), 512'(mon_e.hdr));
      end
    end
    prev_stall  = out_tvalid && !out_tready;
    prev.data   = out_tdata;
    prev.keep   = out_tkeep;
    prev.last   = out_tlast;
    prev.vendor = out_tuser_vendor;
    prev.hvalid = out_tuser_hvalid;
    prev.hdr    = out_tuser_hdr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];
  pkt_t p;
  pkt_t pa[4];
  pkt_t pb[4];
  int   start;
  int   rr_exp;
  int   first;

  initial begin
    vt[0] = '{0, 3, 1'b1, 1'b0, 3};
    vt[1] = '{1, 1, 1'b0, 1'b1, 1};
    vt[2] = '{0, 1, 1'b1, 1'b0, 1};
    vt[3] = '{1, 2, 1'b0, 1'b0, 1};
    vt[4] = '{0, 2, 1'b1, 1'b1, 2};
    vt[5] = '{0, 4, 1'b1, 1'b0, 4};
    vt[6] = '{1, 5, 1'b0, 1'b1, 4};
    vt[7] = '{0, 7, 1'b1, 1'b0, 7};

    rst_n = 1'b0;
    out_tready = 1'b1;
    tx_tvalid = 1'b0; tx_tdata = '0; tx_tkeep = '0; tx_tlast = 1'b0; tx_tuser_vendor = 1'b0;
    txreq_tvalid = 1'b1; txreq_tdata = '0; txreq_tkeep = '0; txreq_tlast = 1'b0; txreq_tuser_vendor = 1'b0;
    tx_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state, with both inputs requesting.
    chk("reset_data", out_tdata, 512'h0);
    chk("reset_ctl", 512'({out_tvalid, out_tkeep, out_tlast, out_tuser_last_segment, out_tuser_vendor,
                           out_tuser_hvalid, out_tuser_hdr, tx_tready, txreq_tready}), 512'(0));
    chk("reset_stats", 512'({stat_tx_pkts, stat_txreq_pkts}), 512'(0));
    tx_tvalid = 1'b0;
    txreq_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in BODY: the output is held by backpressure, then reset is applied.
    out_tready = 1'b0;
    p = make_pkt(5, 1'b1, 1'b1, 1'b0);
    send_beat(0, p.d[0], p.k[0], 1'b0, p.vend);
    send_beat(0, p.d[1], p.k[1], 1'b0, p.vend);
    @(negedge clk);
    chk("midpkt_valid", 512'(out_tvalid), 512'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_data", out_tdata, 512'h0);
    chk("midrst_ctl", 512'({out_tvalid, out_tkeep, out_tlast, out_tuser_vendor, out_tuser_hvalid,
                            out_tuser_hdr, tx_tready, txreq_tready}), 512'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_tready = 1'b1;
    p = make_pkt(2, 1'b1, 1'b0, 1'b0);
    start = beats_seen;
    predict(p);
    send_pkt(0, p);
    drain();
    chk("postrst_beats", 512'(beats_seen - start), 512'(2));

    // Table-driven packets, one source at a time.
    rr_exp = 0;
    for (int i = 0; i < 8; i++) begin
      p = make_pkt(vt[i].n, vt[i].up, vt[i].vend, (i == 0));
      start = beats_seen;
      predict(p);
      send_pkt(vt[i].src, p);
      drain();
      chk($sformatf("vec%0d_beats", i), 512'(beats_seen - start), 512'(vt[i].exp_beats));
      rr_exp = (vt[i].src == 0) ? 1 : 0;
    end

    // Both sources continuously valid: packets must alternate, starting at rr.
    first = rr_exp;
    for (int i = 0; i < 4; i++) begin
      pa[i] = make_pkt(2, (i % 2 == 0), 1'b0, 1'b0);
      pb[i] = make_pkt(2, (i % 2 == 1), 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      predict(pa[i]);
      predict(pb[i]);
    end
    start = beats_seen;
    fork
      begin
        for (int i = 0; i < 4; i++) send_pkt(first, pa[i]);
      end
      begin
        for (int j = 0; j < 4; j++) send_pkt(1 - first, pb[j]);
      end
    join
    drain();
    chk("alt_beats", 512'(beats_seen - start), 512'(12));

    // Toggling out_tready over a 4-beat packet.
    p = make_pkt(4, 1'b1, 1'b1, 1'b0);
    start = beats_seen;
    predict(p);
    fork
      send_pkt(0, p);
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          #1;
          out_tready = !out_tready;
        end
      end
    join
    out_tready = 1'b1;
    drain();
    chk("stall_beats", 512'(beats_seen - start), 512'(4));

    @(negedge clk);
`ifdef OFS_FIM_PCIE_SS_TX_IB2SB_STATS_EN
    chk("stat_tx", 512'(stat_tx_pkts), 512'(cnt_tx));
    chk("stat_txreq", 512'(stat_txreq_pkts), 512'(cnt_rq));
`else
    chk("stat_tx", 512'(stat_tx_pkts), 512'(0));
    chk("stat_txreq", 512'(stat_txreq_pkts), 512'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
